// File: rtl/wb_write_arbiter_if.sv
// Writeback-side bundle for wb_write_arbiter: pipeline and mult/div sources in,
// register-file write port, flow control and hazard mask out.
interface wb_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        wb_stall;
  logic [31:0] pending_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  modport slave (
    input  wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data,
    output md_ready, wb_stall, pending_mask, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport master (
    output wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data,
    input  md_ready, wb_stall, pending_mask, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single-write-port arbiter: pipeline writeback has priority, mult/div results wait
// in a FIFO and are forced out by a one-cycle pipeline stall if they starve.
module wb_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                clock,
  input logic                ctrl_reset,
  wb_write_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      mem_reg_q  [DEPTH];
  logic [4:0]      mem_reg_d  [DEPTH];
  logic [31:0]     mem_data_q [DEPTH];
  logic [31:0]     mem_data_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            we_q, we_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            slot_taken, empty, ready, push, pop;
  logic [PtrW-1:0] offs;
  logic [31:0]     pending;

  always_comb begin
    slot_taken = bus.wb_valid && (bus.wb_reg != 5'd0) && !stall_q;
    empty      = (count_q == '0);
    ready      = (count_q != CntW'(DEPTH));
    // Results for reg 0 are acknowledged but never queued.
    push       = bus.md_valid && ready && (bus.md_reg != 5'd0);
    pop        = !slot_taken && !empty;

    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_reg_d[tail_q]  = bus.md_reg;
      mem_data_d[tail_q] = bus.md_data;
    end

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CntW'(push) - CntW'(pop);

    starve_d = (pop || empty) ? '0 : starve_q + 1'b1;
    // A stall cycle always pops, so the stall can never repeat back-to-back.
    stall_d  = !pop && !empty && (starve_q == StW'(STARVE_LIMIT - 1));

    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (slot_taken) begin
      we_d    = 1'b1;
      wreg_d  = bus.wb_reg;
      wdata_d = bus.wb_data;
    end else if (pop) begin
      we_d    = 1'b1;
      wreg_d  = mem_reg_q[head_q];
      wdata_d = mem_data_q[head_q];
    end
  end

  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    pending = '0;
    offs    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PtrW'(i) - head_q;
      if ({1'b0, offs} < count_q) begin
        pending[mem_reg_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_reg_q  <= mem_reg_d;
    mem_data_q <= mem_data_d;
  end

  assign bus.md_ready         = ready;
  assign bus.wb_stall         = stall_q;
  assign bus.pending_mask     = pending;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: a vector table for single-cycle behaviour and
// hand-written sequences for starvation, full-FIFO pop/push and reset mid-drain.
module tb_wb_write_arbiter;

  logic clock = 1'b0;
  logic ctrl_reset;
  int   checks = 0;
  int   passed = 0;

  wb_write_arbiter_if ifc ();

  wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (ifc)
  );

  always #5 clock = ~clock;

  // {we, wreg, wdata, md_ready, wb_stall, pending_mask}
  function automatic logic [71:0] pack(input logic we, input logic [4:0] wr,
                                       input logic [31:0] wd, input logic rdy,
                                       input logic st, input logic [31:0] pm);
    return {we, wr, wd, rdy, st, pm};
  endfunction

  function automatic logic [71:0] obs();
    return {ifc.ctrl_writeEnable, ifc.ctrl_writeReg, ifc.data_writeReg, ifc.md_ready,
            ifc.wb_stall, ifc.pending_mask};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic rst, input logic wv, input logic [4:0] wr,
                       input logic [31:0] wd, input logic mv, input logic [4:0] mr,
                       input logic [31:0] md);
    ctrl_reset   = rst;
    ifc.wb_valid = wv;
    ifc.wb_reg   = wr;
    ifc.wb_data  = wd;
    ifc.md_valid = mv;
    ifc.md_reg   = mr;
    ifc.md_data  = md;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pipeline must never write a register still owned by a queued mult/div result.
  always @(negedge clock) begin
    if (!ctrl_reset && ifc.wb_valid === 1'b1 && ifc.wb_reg != 5'd0 &&
        ifc.pending_mask[ifc.wb_reg] === 1'b1) begin
      checks++;
      $display("FAIL contract: wb_reg %0d issued with pending_mask %h", ifc.wb_reg,
               ifc.pending_mask);
    end
  end

  typedef struct {
    logic        rst;
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [71:0] exp;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [4:0]  wr;
    logic [31:0] pm;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, pack(0, 0, 0, 1, 0, 0)};
    vt[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0, pack(1, 5, 32'hDEADBEEF, 1, 0, 0)};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, pack(0, 5, 32'hDEADBEEF, 1, 0, 0)};
    vt[3]  = '{0, 0, 0, 0, 1, 7, 32'h12345678, pack(0, 5, 32'hDEADBEEF, 1, 0, 32'h80)};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, pack(1, 7, 32'h12345678, 1, 0, 0)};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 0, pack(0, 7, 32'h12345678, 1, 0, 0)};
    vt[6]  = '{0, 1, 0, 32'hBBBB, 1, 0, 32'hAAAA, pack(0, 7, 32'h12345678, 1, 0, 0)};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, pack(0, 7, 32'h12345678, 1, 0, 0)};
    vt[8]  = '{0, 1, 9, 32'h9, 1, 3, 32'h33, pack(1, 9, 32'h9, 1, 0, 32'h8)};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, pack(1, 3, 32'h33, 1, 0, 0)};
    vt[10] = '{0, 1, 4, 32'h44, 1, 2, 32'h22, pack(1, 4, 32'h44, 1, 0, 32'h4)};
    vt[11] = '{0, 1, 6, 32'h66, 0, 0, 0, pack(1, 6, 32'h66, 1, 0, 32'h4)};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, pack(1, 2, 32'h22, 1, 0, 0)};

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst, vt[i].wv, vt[i].wr, vt[i].wd, vt[i].mv, vt[i].mr, vt[i].md);
      tick();
      chk($sformatf("vec%0d", i), obs(), vt[i].exp);
    end

    // Starvation: pipeline busy every cycle while four results queue up.
    for (int c = 0; c <= 10; c++) begin
      wr = (c <= 8) ? 5'(16 + c) : 5'd25;
      drive(1'b0, 1'b1, wr, 32'hA000 + 32'(wr), (c < 4), 5'(c + 1), 32'h100 + 32'(c + 1));
      tick();
      if (c <= 8) begin
        pm = (c >= 3) ? 32'h1E : ((32'd1 << (c + 2)) - 32'd1) & ~32'd1;
        chk($sformatf("starve_c%0d", c), obs(),
            pack(1, 5'(16 + c), 32'hA010 + 32'(c), (c < 3), (c == 8), pm));
      end else if (c == 9) begin
        chk("stall_pop", obs(), pack(1, 1, 32'h101, 1, 0, 32'h1C));
      end else begin
        chk("held_wb", obs(), pack(1, 25, 32'hA019, 1, 0, 32'h1C));
      end
    end

    // Refill to full, then a free slot with a push that must be rejected.
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    tick();
    chk("drain_r2", obs(), pack(1, 2, 32'h102, 1, 0, 32'h18));
    drive(1'b0, 1'b1, 17, 32'hA011, 1'b1, 5, 32'h105);
    tick();
    chk("fill_r5", obs(), pack(1, 17, 32'hA011, 1, 0, 32'h38));
    drive(1'b0, 1'b1, 18, 32'hA012, 1'b1, 6, 32'h106);
    tick();
    chk("full", obs(), pack(1, 18, 32'hA012, 0, 0, 32'h78));
    drive(1'b0, 1'b0, 0, 0, 1'b1, 7, 32'h107);
    tick();
    chk("full_pop_reject", obs(), pack(1, 3, 32'h103, 1, 0, 32'h70));
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    tick();
    chk("drain_r4", obs(), pack(1, 4, 32'h104, 1, 0, 32'h60));
    tick();
    chk("drain_r5", obs(), pack(1, 5, 32'h105, 1, 0, 32'h40));
    tick();
    chk("drain_r6", obs(), pack(1, 6, 32'h106, 1, 0, 32'h0));
    tick();
    chk("drained", obs(), pack(0, 6, 32'h106, 1, 0, 32'h0));

    // Reset while three entries wait and the stall is asserted.
    for (int c = 0; c <= 8; c++) begin
      drive(1'b0, 1'b1, 5'(16 + c), 32'hA010 + 32'(c), (c < 3), 5'(8 + c),
            32'h208 + 32'(c));
      tick();
      pm = (c == 0) ? 32'h100 : (c == 1) ? 32'h300 : 32'h700;
      chk($sformatf("prerst_c%0d", c), obs(),
          pack(1, 5'(16 + c), 32'hA010 + 32'(c), 1, (c == 8), pm));
    end
    drive(1'b1, 1'b1, 25, 32'hA019, 1'b0, 0, 0);
    tick();
    chk("reset_mid", obs(), pack(0, 0, 0, 1, 0, 0));
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("postrst_%0d", c), obs(), pack(0, 0, 0, 1, 0, 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sits directly upstream of the 32x32 register file and drives its single write port: ctrl_writeEnable, ctrl_writeReg and data_writeReg.
- Merges two writeback sources:
  - the in-order pipeline writeback, which has priority and normally cannot be stalled;
  - results from the multi-cycle mult/div unit, held in a small FIFO until a free write slot appears.
- Exports a pending-write mask for hazard detection and a starvation stall that forces a FIFO drain.

Parameters:
- DEPTH, 4: mult/div result FIFO entries; power of 2, minimum 2.
- STARVE_LIMIT, 8: consecutive cycles the FIFO head may wait before wb_stall is raised; minimum 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  pipeline writeback request.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline writeback data.
- md_valid  in  1  mult/div result valid.
- md_reg  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- md_ready  out  1  FIFO can accept a result; equals !full, from registered count.
- wb_stall  out  1  registered; pipeline must hold its writeback next cycle.
- pending_mask  out  32  bit r set if any FIFO entry targets r.
- ctrl_writeEnable  out  1  registered regfile write enable.
- ctrl_writeReg  out  5  registered regfile write address.
- data_writeReg  out  32  registered regfile write data.

Behaviour:
- Reset: ctrl_reset is synchronous and active-high. On a rising edge with ctrl_reset=1:
  - FIFO is emptied (count=0, pointers=0) and the starve counter clears;
  - wb_stall, ctrl_writeEnable, ctrl_writeReg and data_writeReg all go to 0;
  - md_ready=1 and pending_mask=0 the following cycle.
  - Any in-flight result is dropped.
- Enqueue:
  - A result is accepted when md_valid && md_ready.
  - If md_reg==0 the result is accepted but discarded: no entry is written and the count is unchanged.
  - Otherwise {md_reg, md_data} is written at the tail and tail wraps modulo DEPTH.
- Pipeline slot:
  - wb_valid && wb_reg!=0 && !wb_stall means the slot is taken.
  - A pipeline write to reg 0 counts as a free slot.
- Arbitration, evaluated each cycle:
  - Pipeline slot taken: output registers load {1, wb_reg, wb_data} next edge.
  - Else, FIFO non-empty: pop head (head wraps modulo DEPTH) and output registers load {1, head_reg, head_data}.
  - Else: ctrl_writeEnable=0 next edge; ctrl_writeReg and data_writeReg hold.
- Latency:
  - Pipeline write reaches the port 1 cycle after it is presented.
  - Mult/div write reaches the port at least 2 cycles after acceptance; there is no FIFO bypass.
  - The regfile samples on the falling edge of the same cycle the outputs are valid.
- Simultaneous push and pop: allowed; count is unchanged. md_ready still follows the pre-edge count, so a full FIFO rejects a push even in a cycle where it pops.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and no pop occurs.
  - It clears on any pop or when the FIFO is empty.
  - When it reaches STARVE_LIMIT-1 with no pop that cycle, wb_stall=1 on the next edge.
  - In a wb_stall=1 cycle:
    - the arbiter ignores wb_* and pops the FIFO;
    - the pipeline must present the same wb_valid, wb_reg and wb_data the following cycle;
    - wb_stall returns to 0 on the following edge and the counter clears.
  - wb_stall is never high for two consecutive cycles.
- pending_mask:
  - Combinational OR of one-hot decodes of all valid FIFO entries.
  - Excludes the output stage.
  - Bit 0 is always 0.
- Contract: the pipeline does not issue a write to a register whose pending_mask bit is set. The verification bench asserts this contract.

Test Plan:
- Reset, then wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF for 1 cycle -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; the cycle after, ctrl_writeEnable=0.
- Idle pipeline; md_valid=1, md_reg=7, md_data=0x12345678 for 1 cycle -> pending_mask=0x80 the next cycle; the write appears at the port 2 cycles after acceptance and pending_mask then returns to 0.
- Pipeline writes every cycle; push 4 md results to regs 1..4 -> md_ready=0 after the 4th; pending_mask=0x1E; wb_stall=1 STARVE_LIMIT=8 cycles after the first push, with the reg1 result written during the stall cycle; the held pipeline write appears the cycle after.
- FIFO full, with a pop (free slot) and md_valid=1 in the same cycle -> push rejected (md_ready=0); count drops to 3; md_ready=1 the next cycle.
- md_reg=0 and wb_reg=0 -> no FIFO entry; pending_mask=0; ctrl_writeEnable stays 0; md_ready stays 1.
- ctrl_reset asserted with 3 FIFO entries and wb_stall=1 -> next cycle FIFO empty, pending_mask=0, wb_stall=0, ctrl_writeEnable=0; no queued write ever appears afterward.
